led_seq_ctrl: RTL

- Arbitrates the 4-bit LED bank between two requesters.
- Each requester submits a pattern, a duration in ticks and a blink flag over a valid/ready handshake.
- The block grants requests round-robin, shows the winning pattern for its duration, forces a blank gap, then re-arbitrates.
- Sits between system status logic / user logic and the board LED pins.

---
 rtl/led_seq_pkg.sv | 23 ++
 rtl/led_tick_gen.sv | 27 ++
 rtl/led_seq_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer blocks: FSM state encoding,
// LED bank width and tick-divider helpers.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int LED_W = 4;

    // Number of sysclk cycles per display tick.
    function automatic int tick_div_f(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Counter width able to hold 0..div-1.
    function automatic int tick_cnt_w_f(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running tick divider: counts 0..DIV-1 and pulses tick for one
// sysclk cycle on the last count. Never stalls.
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic sysclk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = tick_cnt_w_f(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Wrap-around divider counter.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)              r_cnt <= '0;
        else if (r_cnt == LAST)  r_cnt <= '0;
        else                     r_cnt <= r_cnt + CW'(1);
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: round-robin arbitration between two requesters,
// shows the winning pattern for its duration (optionally blinking), then
// forces a blank gap before re-arbitrating.
// Optional idle heartbeat on led[0]: define LED_SEQ_IDLE_HEARTBEAT_EN.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int CLK_HZ    = 125000000,
    parameter int TICK_HZ   = 1000,
    parameter int DUR_W     = 8,
    parameter int GAP_TICKS = 2,
    parameter int HB_TICKS  = 500
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [LED_W-1:0] req0_pattern,
    input  logic [DUR_W-1:0] req0_dur,
    input  logic             req0_blink,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [LED_W-1:0] req1_pattern,
    input  logic [DUR_W-1:0] req1_dur,
    input  logic             req1_blink,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic             grant_id
);

    localparam int TICK_DIV = tick_div_f(CLK_HZ, TICK_HZ);
    localparam int GW       = $clog2(GAP_TICKS + 1);

    state_t           r_state, w_state_nxt;
    logic [LED_W-1:0] r_pat, w_pat_nxt;
    logic             r_blink, w_blink_nxt;
    logic [DUR_W-1:0] r_rem, w_rem_nxt;
    logic             r_phase, w_phase_nxt;
    logic [GW-1:0]    r_gap, w_gap_nxt;
    logic             r_grant, w_grant_nxt;
    logic             r_prio, w_prio_nxt;   // 1: req1 wins a tie
    logic [LED_W-1:0] r_led, w_led_nxt;

    logic             w_tick;
    logic             w_idle;
    logic             w_win;
    logic             w_xfer;
    logic [DUR_W-1:0] w_dur;

    led_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .tick   (w_tick)
    );

    // Arbitration: a lone requester wins; on a tie the pointer decides.
    assign w_idle = (r_state == ST_IDLE);
    assign w_win  = req1_valid && (!req0_valid || r_prio);
    assign w_xfer = w_idle && (req0_valid || req1_valid);
    assign w_dur  = w_win ? req1_dur : req0_dur;

    assign req0_ready = w_idle && req0_valid && !w_win;
    assign req1_ready = w_idle && req1_valid &&  w_win;

`ifdef LED_SEQ_IDLE_HEARTBEAT_EN
    localparam int HW = $clog2(HB_TICKS + 1);

    logic [HW-1:0] r_hb_cnt, w_hb_cnt_nxt;
    logic          r_hb, w_hb_nxt;

    // Heartbeat runs only while idle and restarts from led[0]=0.
    always_comb begin
        w_hb_cnt_nxt = '0;
        w_hb_nxt     = 1'b0;
        if (w_idle && !w_xfer) begin
            w_hb_cnt_nxt = r_hb_cnt;
            w_hb_nxt     = r_hb;
            if (w_tick) begin
                if (r_hb_cnt == HW'(HB_TICKS - 1)) begin
                    w_hb_cnt_nxt = '0;
                    w_hb_nxt     = ~r_hb;
                end else begin
                    w_hb_cnt_nxt = r_hb_cnt + HW'(1);
                end
            end
        end
    end

    // Heartbeat state registers.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb_cnt <= '0;
            r_hb     <= 1'b0;
        end else begin
            r_hb_cnt <= w_hb_cnt_nxt;
            r_hb     <= w_hb_nxt;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state, datapath and LED image for the next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_blink_nxt = r_blink;
        w_rem_nxt   = r_rem;
        w_phase_nxt = r_phase;
        w_gap_nxt   = r_gap;
        w_grant_nxt = r_grant;
        w_prio_nxt  = r_prio;
        w_led_nxt   = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = ST_SHOW;
                    w_pat_nxt   = w_win ? req1_pattern : req0_pattern;
                    w_blink_nxt = w_win ? req1_blink : req0_blink;
                    w_rem_nxt   = (w_dur == '0) ? DUR_W'(1) : w_dur;
                    w_phase_nxt = 1'b1;
                    w_grant_nxt = w_win;
                    w_prio_nxt  = ~w_win;
                end
            end
            ST_SHOW: begin
                if (w_tick) begin
                    w_phase_nxt = ~r_phase;
                    w_rem_nxt   = r_rem - DUR_W'(1);
                    if (r_rem <= DUR_W'(1)) begin
                        w_state_nxt = ST_GAP;
                        w_gap_nxt   = GW'(GAP_TICKS);
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    w_gap_nxt = r_gap - GW'(1);
                    if (r_gap <= GW'(1)) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // LED register follows the next state so the pattern appears the
        // cycle after the transfer.
        if (w_state_nxt == ST_SHOW) begin
            w_led_nxt = (w_blink_nxt && !w_phase_nxt) ? '0 : w_pat_nxt;
        end
`ifdef LED_SEQ_IDLE_HEARTBEAT_EN
        else if (w_state_nxt == ST_IDLE) begin
            w_led_nxt = {{(LED_W-1){1'b0}}, w_hb_nxt};
        end
`endif
    end

    // Datapath and output registers.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat   <= '0;
            r_blink <= 1'b0;
            r_rem   <= '0;
            r_phase <= 1'b1;
            r_gap   <= '0;
            r_grant <= 1'b0;
            r_prio  <= 1'b0;
            r_led   <= '0;
        end else begin
            r_pat   <= w_pat_nxt;
            r_blink <= w_blink_nxt;
            r_rem   <= w_rem_nxt;
            r_phase <= w_phase_nxt;
            r_gap   <= w_gap_nxt;
            r_grant <= w_grant_nxt;
            r_prio  <= w_prio_nxt;
            r_led   <= w_led_nxt;
        end
    end

    assign led      = r_led;
    assign busy     = (r_state != ST_IDLE);
    assign grant_id = r_grant;

endmodule
